// File: rtl/kfps2kb_command_sender.sv
// rtl/kfps2kb_command_sender.sv - PS/2 host-to-device command byte transmitter
//
// Ports:
//   clock, reset                      system clock, synchronous active-high reset
//   device_clock, device_data         PS/2 pin levels (asynchronous)
//   device_clock_out, device_data_out open-drain drives, 0 = pull low, 1 = release
//   send_request, send_data           one-cycle strobe plus command byte
//   busy, done, error                 transfer status; error qualified by done
module kfps2kb_command_sender #(
  parameter logic [15:0] inhibit_time = 16'd100,
  parameter logic [15:0] setup_time   = 16'd16,
  parameter logic [15:0] start_time   = 16'd2000,
  parameter logic [15:0] over_time    = 16'd1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       device_clock,
  input  logic       device_data,
  output logic       device_clock_out,
  output logic       device_data_out,
  input  logic       send_request,
  input  logic [7:0] send_data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SETUP,
    S_WAIT_FIRST,
    S_SHIFT,
    S_FINISH
  } state_t;

  state_t      state;
  logic        clk_meta, clk_sync, clk_sync_d;
  logic        data_meta, data_sync;
  logic        fall;
  logic [15:0] timer;
  logic [15:0] timer_inc;
  logic [3:0]  bit_idx;
  logic [7:0]  shreg;
  logic        parity;
  logic        frame_bit;

  // Two-flop synchronizers; the falling edge is registered so detection
  // lands three cycles after the pin edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta   <= 1'b1;
      clk_sync   <= 1'b1;
      clk_sync_d <= 1'b1;
      data_meta  <= 1'b1;
      data_sync  <= 1'b1;
      fall       <= 1'b0;
    end else begin
      clk_meta   <= device_clock;
      clk_sync   <= clk_meta;
      clk_sync_d <= clk_sync;
      data_meta  <= device_data;
      data_sync  <= data_meta;
      fall       <= clk_sync_d & ~clk_sync;
    end
  end

  // Saturating increment; comparing the incremented value makes each phase
  // last exactly its limit in cycles, counted from state entry.
  assign timer_inc = (timer == 16'hFFFF) ? timer : timer + 16'd1;

  // Bit driven after the current falling edge: data LSB first, parity, stop.
  always_comb begin
    frame_bit = 1'b1;
    if (bit_idx < 4'd8) begin
      frame_bit = shreg[bit_idx[2:0]];
    end else if (bit_idx == 4'd8) begin
      frame_bit = parity;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= S_IDLE;
      device_clock_out <= 1'b1;
      device_data_out  <= 1'b1;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      timer            <= 16'd0;
      bit_idx          <= 4'd0;
      shreg            <= 8'd0;
      parity           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          device_clock_out <= 1'b1;
          device_data_out  <= 1'b1;
          busy             <= 1'b0;
          if (send_request) begin
            shreg            <= send_data;
            parity           <= ~^send_data;
            timer            <= 16'd0;
            bit_idx          <= 4'd0;
            busy             <= 1'b1;
            device_clock_out <= 1'b0;
            state            <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          timer <= timer_inc;
          if (timer_inc >= inhibit_time) begin
            timer           <= 16'd0;
            device_data_out <= 1'b0;
            state           <= S_SETUP;
          end
        end

        S_SETUP: begin
          timer <= timer_inc;
          if (timer_inc >= setup_time) begin
            timer            <= 16'd0;
            device_clock_out <= 1'b1;
            state            <= S_WAIT_FIRST;
          end
        end

        S_WAIT_FIRST: begin
          timer <= timer_inc;
          if (fall) begin
            timer           <= 16'd0;
            device_data_out <= shreg[0];
            bit_idx         <= 4'd1;
            state           <= S_SHIFT;
          end else if (timer_inc >= start_time) begin
            device_clock_out <= 1'b1;
            device_data_out  <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b1;
            error            <= 1'b1;
            state            <= S_FINISH;
          end
        end

        S_SHIFT: begin
          timer <= timer_inc;
          if (fall) begin
            timer <= 16'd0;
            if (bit_idx == 4'd10) begin
              // Eleventh falling edge: device ACK must pull data low.
              device_clock_out <= 1'b1;
              device_data_out  <= 1'b1;
              busy             <= 1'b0;
              done             <= 1'b1;
              error            <= data_sync;
              state            <= S_FINISH;
            end else begin
              device_data_out <= frame_bit;
              bit_idx         <= bit_idx + 4'd1;
            end
          end else if (timer_inc >= over_time) begin
            device_clock_out <= 1'b1;
            device_data_out  <= 1'b1;
            busy             <= 1'b0;
            done             <= 1'b1;
            error            <= 1'b1;
            state            <= S_FINISH;
          end
        end

        S_FINISH: begin
          error <= 1'b0;
          timer <= 16'd0;
          state <= S_IDLE;
        end

        default: begin
          device_clock_out <= 1'b1;
          device_data_out  <= 1'b1;
          busy             <= 1'b0;
          error            <= 1'b0;
          state            <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kfps2kb_command_sender.sv
// tb/tb_kfps2kb_command_sender.sv - scoreboard bench for kfps2kb_command_sender
module tb_kfps2kb_command_sender;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       device_clock;
  logic       device_data;
  logic       device_clock_out;
  logic       device_data_out;
  logic       send_request = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       busy;
  logic       done;
  logic       error;

  // Device side of the open-drain pair
  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  assign device_clock = device_clock_out & dev_clk;
  assign device_data  = device_data_out & dev_data;

  kfps2kb_command_sender #(
    .inhibit_time(16'd8),
    .setup_time  (16'd4),
    .start_time  (16'd50),
    .over_time   (16'd20)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .device_clock    (device_clock),
    .device_data     (device_data),
    .device_clock_out(device_clock_out),
    .device_data_out (device_data_out),
    .send_request    (send_request),
    .send_data       (send_data),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wf_cyc = 0;
  int done_count = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [7:0] b;
    logic       err;
    logic       chk_bits;
    int         wait_cyc;
  } exp_t;
  exp_t sb[$];

  // Device model configuration and observations
  logic       dev_no_clock = 1'b0;
  int         dev_stop_after = 11;
  logic       dev_ack_bad = 1'b0;
  int         dev_falls = 0;
  logic [9:0] rx = 10'd0;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // PS/2 keyboard: 10-cycle half period, samples host data on rising edges,
  // drives ACK low before the 11th falling edge.
  initial begin
    forever begin
      wait (device_clock_out == 1'b0);
      wait (device_clock_out == 1'b1 && device_data_out == 1'b0);
      if (!dev_no_clock) begin
        wait_cyc(5);
        for (int k = 1; k <= 11; k++) begin
          if (k > dev_stop_after) break;
          dev_clk = 1'b0;
          dev_falls++;
          wait_cyc(10);
          dev_clk = 1'b1;
          if (k <= 10) rx[k-1] = device_data;
          if (k == 10 && !dev_ack_bad) dev_data = 1'b0;
          wait_cyc(10);
        end
        dev_data = 1'b1;
        dev_clk  = 1'b1;
      end
    end
  end

  // Pin-phase monitor: inhibit and setup lengths, WAIT_FIRST entry time
  int   inh_cnt = 0;
  int   set_cnt = 0;
  logic prev_co = 1'b1;
  always @(negedge clock) begin
    if (!reset) begin
      if (device_clock_out == 1'b0 && device_data_out == 1'b1) begin
        inh_cnt++;
      end else if (device_clock_out == 1'b0 && device_data_out == 1'b0) begin
        set_cnt++;
      end else if (device_clock_out == 1'b1) begin
        if (prev_co == 1'b0) begin
          chk("inhibit_cycles", inh_cnt, 8);
          chk("setup_cycles", set_cnt, 4);
          wf_cyc = cyc;
        end
        inh_cnt = 0;
        set_cnt = 0;
      end
      prev_co = device_clock_out;
    end
  end

  // Scoreboard monitor
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done === 1'b1) begin
      done_count++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no transfer at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("error", error, e.err);
        chk("clock_released", device_clock_out, 1);
        chk("data_released", device_data_out, 1);
        chk("busy_at_done", busy, 0);
        if (e.chk_bits) chk("frame_bits", rx, {1'b1, ~^e.b, e.b});
        if (e.wait_cyc >= 0) chk("start_timeout_cycles", cyc - wf_cyc, e.wait_cyc);
      end
    end
  end

  task automatic push_exp(input logic [7:0] b, input logic err, input logic cb, input int wc);
    exp_t e;
    e.b = b; e.err = err; e.chk_bits = cb; e.wait_cyc = wc;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clock); #1;
    send_request = 1'b1;
    send_data    = b;
    @(posedge clock); #1;
    send_request = 1'b0;
    send_data    = 8'h00;
    chk("accept_busy", busy, 1);
    chk("accept_clock_low", device_clock_out, 0);
  endtask

  task automatic wait_idle(input string name, input int budget);
    logic ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got busy=%0d pending=%0d expected idle", name, busy, sb.size());
      sb.delete();
    end
    wait_cyc(3);
  endtask

  task automatic wait_falls(input int target, input int budget);
    logic ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dev_falls >= target) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock);
    end
    #1;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL falls_timeout: got %0d expected %0d", dev_falls, target);
    end
  endtask

  initial begin
    int base;
    int dc;
    wait_cyc(3);
    reset = 1'b0;
    chk("reset_clock_out", device_clock_out, 1);
    chk("reset_data_out", device_data_out, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);

    // 0xED: bits 1,0,1,1,0,1,1,1 parity 1 stop 1
    push_exp(8'hED, 1'b0, 1'b1, -1);
    send(8'hED);
    wait_idle("send_ed", 1000);
    chk("ed_bits_literal", rx, 10'b11_1110_1101);

    // 0x01, request in FINISH cycle ignored, then 0x00
    push_exp(8'h01, 1'b0, 1'b1, -1);
    send(8'h01);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clock);
        if (done) begin
          seen = 1'b1;
          break;
        end
      end
      chk("done_01_seen", seen, 1);
      send_request = 1'b1;
      send_data    = 8'h55;
      @(posedge clock); #1;
      send_request = 1'b0;
      wait_cyc(3);
      chk("finish_request_ignored_busy", busy, 0);
      chk("finish_request_ignored_clock", device_clock_out, 1);
    end
    chk("parity_01", rx[8], 0);
    push_exp(8'h00, 1'b0, 1'b1, -1);
    send(8'h00);
    wait_idle("send_00", 1000);
    chk("parity_00", rx[8], 1);

    // Device never clocks: error exactly 50 cycles after WAIT_FIRST entry
    dev_no_clock = 1'b1;
    push_exp(8'hFF, 1'b1, 1'b0, 50);
    send(8'hFF);
    wait_idle("no_clock", 1000);
    dev_no_clock = 1'b0;

    // Device stalls after the 4th falling edge
    dev_stop_after = 4;
    push_exp(8'hF3, 1'b1, 1'b0, -1);
    send(8'hF3);
    wait_idle("stall", 1000);
    dev_stop_after = 11;
    wait_cyc(30);

    // Missing ACK
    dev_ack_bad = 1'b1;
    push_exp(8'hA5, 1'b1, 1'b1, -1);
    send(8'hA5);
    wait_idle("no_ack", 1000);
    dev_ack_bad = 1'b0;

    // Mid-frame request ignored, byte unchanged
    base = dev_falls;
    push_exp(8'h5A, 1'b0, 1'b1, -1);
    send(8'h5A);
    wait_falls(base + 3, 1000);
    send_request = 1'b1;
    send_data    = 8'hFF;
    @(posedge clock); #1;
    send_request = 1'b0;
    send_data    = 8'h00;
    chk("midframe_busy", busy, 1);
    wait_idle("midframe", 1000);

    // Reset during bit 5: no done, lines released
    dev_stop_after = 6;
    base = dev_falls;
    dc = done_count;
    send(8'hC3);
    wait_falls(base + 6, 1000);
    wait_cyc(6);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    chk("abort_clock_out", device_clock_out, 1);
    chk("abort_data_out", device_data_out, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_error", error, 0);
    wait_cyc(80);
    chk("abort_no_done", done_count, dc);
    dev_stop_after = 11;

    // Recovery
    push_exp(8'h7E, 1'b0, 1'b1, -1);
    send(8'h7E);
    wait_idle("recover", 1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
